// File: rtl/id_stage.sv
// Instruction decode stage: 32x32 register file with WB bypass, immediate
// generator, control decode, load-use hazard detection and the ID/EX register.
module id_stage #(
   parameter int DATA_BITS     = 32,
   parameter int ADDR_BITS     = 32,
   parameter int REG_ADDR_BITS = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_BITS-1:0]     IFID_Instr_out,
   input  logic [ADDR_BITS-1:0]     IFID_pc_out,
   input  logic                     branch_flush,
   input  logic                     wb_RegWrite,
   input  logic [REG_ADDR_BITS-1:0] wb_rd,
   input  logic [DATA_BITS-1:0]     wb_data,
   output logic                     pc_write,
   output logic                     IFID_RegWrite,
   output logic [ADDR_BITS-1:0]     IDEX_pc,
   output logic [DATA_BITS-1:0]     IDEX_rs1_data,
   output logic [DATA_BITS-1:0]     IDEX_rs2_data,
   output logic [DATA_BITS-1:0]     IDEX_imm,
   output logic [REG_ADDR_BITS-1:0] IDEX_rs1,
   output logic [REG_ADDR_BITS-1:0] IDEX_rs2,
   output logic [REG_ADDR_BITS-1:0] IDEX_rd,
   output logic [6:0]               IDEX_opcode,
   output logic [2:0]               IDEX_funct3,
   output logic                     IDEX_funct7b5,
   output logic                     IDEX_RegWrite,
   output logic                     IDEX_MemRead,
   output logic                     IDEX_MemWrite,
   output logic                     IDEX_Branch
);

   localparam int NUM_REGS = 1 << REG_ADDR_BITS;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic [ADDR_BITS-1:0]     pc;
      logic [DATA_BITS-1:0]     rs1_data;
      logic [DATA_BITS-1:0]     rs2_data;
      logic [DATA_BITS-1:0]     imm;
      logic [REG_ADDR_BITS-1:0] rs1;
      logic [REG_ADDR_BITS-1:0] rs2;
      logic [REG_ADDR_BITS-1:0] rd;
      logic [6:0]               opcode;
      logic [2:0]               funct3;
      logic                     funct7b5;
      logic                     reg_write;
      logic                     mem_read;
      logic                     mem_write;
      logic                     branch;
   } idex_t;

   logic [DATA_BITS-1:0]     instr;
   logic [6:0]               opcode;
   logic [REG_ADDR_BITS-1:0] rs1, rs2, rd;
   logic [DATA_BITS-1:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [DATA_BITS-1:0]     imm, rs1_data, rs2_data;
   logic                     reg_write, mem_read, mem_write, branch;
   logic                     uses_rs1, uses_rs2;
   logic                     wb_active, hazard, stall, bubble;
   logic [DATA_BITS-1:0]     regs [NUM_REGS];
   idex_t                    idex_d, idex_q;

   assign instr  = IFID_Instr_out;
   assign opcode = instr[6:0];
   assign rd     = instr[7 +: REG_ADDR_BITS];
   assign rs1    = instr[15 +: REG_ADDR_BITS];
   assign rs2    = instr[20 +: REG_ADDR_BITS];

   // Register file. x0 is never written, so it stays at its reset value of 0.
   assign wb_active = wb_RegWrite && (wb_rd != '0);

   // NOTE: the register array takes the async reset so no stale operand can
   // survive a mid-run reset; this costs a reset net on every storage bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_active) begin
         regs[wb_rd] <= wb_data;
      end
   end

   // Read ports with write-before-read bypass from WB.
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1 != '0) rs1_data = (wb_active && wb_rd == rs1) ? wb_data : regs[rs1];
      if (rs2 != '0) rs2_data = (wb_active && wb_rd == rs2) ? wb_data : regs[rs2];
   end

   assign imm_i = {{(DATA_BITS-12){instr[31]}}, instr[31:20]};
   assign imm_s = {{(DATA_BITS-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{(DATA_BITS-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {{(DATA_BITS-31){instr[31]}}, instr[30:12], 12'b0};
   assign imm_j = {{(DATA_BITS-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

   // NOTE: every output of this block gets a default first, so an opcode
   // that matches no case item can never infer a latch.
   always_comb begin
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      imm       = '0;
      case (opcode)
         OP_R:      begin reg_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OP_I_ALU:  begin reg_write = 1'b1; uses_rs1 = 1'b1; imm = imm_i; end
         OP_LOAD:   begin reg_write = 1'b1; mem_read = 1'b1; uses_rs1 = 1'b1; imm = imm_i; end
         OP_STORE:  begin mem_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_s; end
         OP_BRANCH: begin branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_b; end
         OP_JAL:    begin reg_write = 1'b1; imm = imm_j; end
         OP_JALR:   begin reg_write = 1'b1; uses_rs1 = 1'b1; imm = imm_i; end
         OP_LUI:    begin reg_write = 1'b1; imm = imm_u; end
         OP_AUIPC:  begin reg_write = 1'b1; imm = imm_u; end
         default:   ;
      endcase
   end

   // Load-use: the load in EX has not produced its data yet. A flush wins,
   // because the dependent instruction is wrong-path and is being discarded.
   assign hazard = idex_q.mem_read && (idex_q.rd != '0) &&
                   ((uses_rs1 && idex_q.rd == rs1) || (uses_rs2 && idex_q.rd == rs2));
   assign stall  = hazard && !branch_flush;
   assign bubble = stall || branch_flush;

   assign pc_write      = !stall;
   assign IFID_RegWrite = !stall;

   always_comb begin
      idex_d           = '0;
      idex_d.pc        = IFID_pc_out;
      idex_d.rs1_data  = rs1_data;
      idex_d.rs2_data  = rs2_data;
      idex_d.imm       = imm;
      idex_d.rs1       = rs1;
      idex_d.rs2       = rs2;
      idex_d.rd        = rd;
      idex_d.opcode    = opcode;
      idex_d.funct3    = instr[14:12];
      idex_d.funct7b5  = instr[30];
      idex_d.reg_write = reg_write;
      idex_d.mem_read  = mem_read;
      idex_d.mem_write = mem_write;
      idex_d.branch    = branch;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        idex_q <= '0;
      else if (bubble) idex_q <= '0;
      else             idex_q <= idex_d;
   end

   assign IDEX_pc       = idex_q.pc;
   assign IDEX_rs1_data = idex_q.rs1_data;
   assign IDEX_rs2_data = idex_q.rs2_data;
   assign IDEX_imm      = idex_q.imm;
   assign IDEX_rs1      = idex_q.rs1;
   assign IDEX_rs2      = idex_q.rs2;
   assign IDEX_rd       = idex_q.rd;
   assign IDEX_opcode   = idex_q.opcode;
   assign IDEX_funct3   = idex_q.funct3;
   assign IDEX_funct7b5 = idex_q.funct7b5;
   assign IDEX_RegWrite = idex_q.reg_write;
   assign IDEX_MemRead  = idex_q.mem_read;
   assign IDEX_MemWrite = idex_q.mem_write;
   assign IDEX_Branch   = idex_q.branch;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a reference model predicts each ID/EX load
// and the fetch enables; predictions are queued and compared after each edge.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] IFID_Instr_out, IFID_pc_out;
   logic        branch_flush, wb_RegWrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        pc_write, IFID_RegWrite;
   logic [31:0] IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm;
   logic [4:0]  IDEX_rs1, IDEX_rs2, IDEX_rd;
   logic [6:0]  IDEX_opcode;
   logic [2:0]  IDEX_funct3;
   logic        IDEX_funct7b5, IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_Branch;

   id_stage dut (
      .clk(clk), .rst(rst),
      .IFID_Instr_out(IFID_Instr_out), .IFID_pc_out(IFID_pc_out),
      .branch_flush(branch_flush),
      .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .pc_write(pc_write), .IFID_RegWrite(IFID_RegWrite),
      .IDEX_pc(IDEX_pc), .IDEX_rs1_data(IDEX_rs1_data), .IDEX_rs2_data(IDEX_rs2_data),
      .IDEX_imm(IDEX_imm), .IDEX_rs1(IDEX_rs1), .IDEX_rs2(IDEX_rs2), .IDEX_rd(IDEX_rd),
      .IDEX_opcode(IDEX_opcode), .IDEX_funct3(IDEX_funct3), .IDEX_funct7b5(IDEX_funct7b5),
      .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
      .IDEX_MemWrite(IDEX_MemWrite), .IDEX_Branch(IDEX_Branch)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc, rs1_data, rs2_data, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic        f7b5, rw, mr, mw, br;
   } idex_t;

   idex_t       exp_q[$];
   idex_t       model_idex;
   logic [31:0] mregs [32];
   logic        last_stall;
   int          checks = 0;
   int          errors = 0;

   function automatic idex_t dut_idex();
      idex_t g;
      g.pc = IDEX_pc; g.rs1_data = IDEX_rs1_data; g.rs2_data = IDEX_rs2_data;
      g.imm = IDEX_imm; g.rs1 = IDEX_rs1; g.rs2 = IDEX_rs2; g.rd = IDEX_rd;
      g.opcode = IDEX_opcode; g.funct3 = IDEX_funct3; g.f7b5 = IDEX_funct7b5;
      g.rw = IDEX_RegWrite; g.mr = IDEX_MemRead; g.mw = IDEX_MemWrite; g.br = IDEX_Branch;
      return g;
   endfunction

   // Encoders for the instructions used in directed tests.
   function automatic logic [31:0] enc_r(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
      return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] rd, logic [2:0] f3,
                                         logic [4:0] rs1, logic [11:0] imm);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(logic [4:0] rs1, logic [4:0] rs2, logic [11:0] imm);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(logic [4:0] rs1, logic [4:0] rs2, logic [12:0] imm);
      return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_j(logic [4:0] rd, logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
   endfunction

   function automatic logic [31:0] model_read(logic [4:0] idx, logic we, logic [4:0] wrd,
                                              logic [31:0] wdata);
      if (idx == 5'd0) return 32'd0;
      if (we && wrd == idx) return wdata;
      return mregs[idx];
   endfunction

   // One ID cycle: drive, predict, check the fetch enables, queue the ID/EX
   // prediction, clock, then pop and compare.
   task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                       input logic flush = 1'b0, input logic we = 1'b0,
                       input logic [4:0] wrd = 5'd0, input logic [31:0] wdata = 32'd0);
      idex_t d, got, e;
      logic  u1, u2, hz, en;
      @(negedge clk);
      IFID_Instr_out = instr; IFID_pc_out = pc; branch_flush = flush;
      wb_RegWrite = we; wb_rd = wrd; wb_data = wdata;
      #1;
      d = '0; u1 = 1'b0; u2 = 1'b0;
      d.pc = pc; d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.rd = instr[11:7];
      d.opcode = instr[6:0]; d.funct3 = instr[14:12]; d.f7b5 = instr[30];
      d.rs1_data = model_read(instr[19:15], we, wrd, wdata);
      d.rs2_data = model_read(instr[24:20], we, wrd, wdata);
      case (instr[6:0])
         7'h33: begin d.rw = 1; u1 = 1; u2 = 1; end
         7'h13: begin d.rw = 1; u1 = 1; d.imm = {{20{instr[31]}}, instr[31:20]}; end
         7'h03: begin d.rw = 1; d.mr = 1; u1 = 1; d.imm = {{20{instr[31]}}, instr[31:20]}; end
         7'h23: begin d.mw = 1; u1 = 1; u2 = 1;
                      d.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]}; end
         7'h63: begin d.br = 1; u1 = 1; u2 = 1;
                      d.imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0}; end
         7'h6F: begin d.rw = 1;
                      d.imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0}; end
         7'h67: begin d.rw = 1; u1 = 1; d.imm = {{20{instr[31]}}, instr[31:20]}; end
         7'h37, 7'h17: begin d.rw = 1; d.imm = {instr[31:12], 12'h000}; end
         default: ;
      endcase
      hz = model_idex.mr && model_idex.rd != 5'd0 &&
           ((u1 && model_idex.rd == d.rs1) || (u2 && model_idex.rd == d.rs2));
      en = !(hz && !flush);
      checks++;
      if (pc_write !== en || IFID_RegWrite !== en) begin
         errors++;
         $display("FAIL %s enables: pc_write=%b IFID_RegWrite=%b required %b",
                  tag, pc_write, IFID_RegWrite, en);
      end
      exp_q.push_back((hz || flush) ? idex_t'('0) : d);
      @(posedge clk);
      if (we && wrd != 5'd0) mregs[wrd] = wdata;
      #1;
      e = exp_q.pop_front();
      model_idex = e;
      last_stall = !en;
      got = dut_idex();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s idex: actual %h required %h", tag, got, e);
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      branch_flush = 1'b0; wb_RegWrite = 1'b0;
      #1;
      checks++;
      if (dut_idex() !== idex_t'('0)) begin
         errors++;
         $display("FAIL reset_idex: actual %h required 0", dut_idex());
      end
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      model_idex = '0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      IFID_Instr_out = 32'd0; IFID_pc_out = 32'd0; wb_rd = 5'd0; wb_data = 32'd0;
      rst = 1'b1; branch_flush = 1'b0; wb_RegWrite = 1'b0;
      #2;
      apply_reset();
      step("reset_first_nop", 32'h0000_0013, 32'h0);
   endtask

   task automatic test_write_bypass();
      step("bypass_x5", enc_r(5'd6, 5'd5, 5'd0), 32'h10, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
      checks++;
      if (IDEX_rs1_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL bypass_rs1: actual %h required deadbeef", IDEX_rs1_data);
      end
      step("write_x0", enc_r(5'd7, 5'd0, 5'd0), 32'h14, 1'b0, 1'b1, 5'd0, 32'h1234);
      checks++;
      if (IDEX_rs1_data !== 32'd0) begin
         errors++;
         $display("FAIL x0_read: actual %h required 0", IDEX_rs1_data);
      end
      step("x5_stored", enc_r(5'd7, 5'd0, 5'd5), 32'h18);
      checks++;
      if (IDEX_rs2_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL x5_stored: actual %h required deadbeef", IDEX_rs2_data);
      end
      step("load_x1", 32'h0000_0013, 32'h1C, 1'b0, 1'b1, 5'd1, 32'h0000_1000);
      step("load_x2", 32'h0000_0013, 32'h20, 1'b0, 1'b1, 5'd2, 32'h0000_0022);
   endtask

   task automatic test_immediates();
      step("imm_addi", enc_i(7'h13, 5'd1, 3'b000, 5'd0, 12'hFFF), 32'h24);
      checks++;
      if (IDEX_imm !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL imm_addi: actual %h required ffffffff", IDEX_imm);
      end
      step("imm_beq", enc_b(5'd1, 5'd2, 13'h1FFC), 32'h28);
      checks++;
      if (IDEX_imm !== 32'hFFFFFFFC || IDEX_Branch !== 1'b1) begin
         errors++;
         $display("FAIL imm_beq: actual imm %h br %b required fffffffc 1", IDEX_imm, IDEX_Branch);
      end
      step("imm_lui", {20'h12345, 5'd2, 7'h37}, 32'h2C);
      checks++;
      if (IDEX_imm !== 32'h12345000) begin
         errors++;
         $display("FAIL imm_lui: actual %h required 12345000", IDEX_imm);
      end
      step("imm_sw", enc_s(5'd1, 5'd2, 12'hFF8), 32'h30);
      step("imm_jal", enc_j(5'd1, 21'h1FF800), 32'h34);
      step("imm_auipc", {20'h80001, 5'd9, 7'h17}, 32'h38);
   endtask

   task automatic test_load_use();
      step("lu_lw", enc_i(7'h03, 5'd3, 3'b010, 5'd1, 12'h0), 32'h40);
      step("lu_add_stall", enc_r(5'd4, 5'd3, 5'd2), 32'h44);
      checks++;
      if (IDEX_RegWrite !== 1'b0 || IDEX_rd !== 5'd0) begin
         errors++;
         $display("FAIL lu_bubble: actual rw %b rd %0d required 0 0", IDEX_RegWrite, IDEX_rd);
      end
      step("lu_add_issue", enc_r(5'd4, 5'd3, 5'd2), 32'h44);
      checks++;
      if (IDEX_rd !== 5'd4 || IDEX_RegWrite !== 1'b1) begin
         errors++;
         $display("FAIL lu_issue: actual rd %0d rw %b required 4 1", IDEX_rd, IDEX_RegWrite);
      end
      step("lu_lw2", enc_i(7'h03, 5'd3, 3'b010, 5'd1, 12'h4), 32'h48);
      step("lu_lui_nostall", {20'h00ABC, 5'd3, 7'h37}, 32'h4C);
   endtask

   task automatic test_flush_priority();
      step("fl_lw", enc_i(7'h03, 5'd3, 3'b010, 5'd1, 12'h0), 32'h50);
      step("fl_add_flush", enc_r(5'd4, 5'd3, 5'd2), 32'h54, 1'b1);
      checks++;
      if (IDEX_RegWrite !== 1'b0 || IDEX_pc !== 32'd0) begin
         errors++;
         $display("FAIL fl_bubble: actual rw %b pc %h required 0 0", IDEX_RegWrite, IDEX_pc);
      end
   endtask

   task automatic test_nop();
      step("nop_zero", 32'h0000_0000, 32'h60);
      checks++;
      if ({IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_Branch} !== 4'b0 ||
          IDEX_imm !== 32'd0) begin
         errors++;
         $display("FAIL nop_zero: actual ctl %b%b%b%b imm %h required 0000 0",
                  IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_Branch, IDEX_imm);
      end
      step("nop_unknown", 32'hFFFF_FFFF, 32'h64);
   endtask

   task automatic test_back_to_back();
      logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                                7'h37, 7'h17, 7'h00};
      logic [31:0] instr, pc;
      instr = 32'h13; pc = 32'h100;
      for (int n = 0; n < 80; n++) begin
         if (!last_stall) begin
            instr = $urandom();
            instr[6:0]   = ops[$urandom_range(0, 9)];
            instr[11:7]  = 5'($urandom_range(0, 4));
            instr[19:15] = 5'($urandom_range(0, 4));
            instr[24:20] = 5'($urandom_range(0, 4));
            pc = pc + 32'd4;
         end
         step("b2b", instr, pc, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 4)), $urandom());
      end
   endtask

   task automatic test_reset_midstream();
      step("mid_wr", enc_r(5'd8, 5'd5, 5'd1), 32'h200, 1'b0, 1'b1, 5'd31, 32'hA5A5A5A5);
      @(negedge clk);
      #2;
      apply_reset();
      for (int i = 1; i < 32; i++)
         step("post_reset_read", enc_r(5'd0, 5'(i), 5'(i)), 32'h300 + 32'(i));
   endtask

   initial begin
      last_stall = 1'b0;
      model_idex = '0;
      test_reset();
      test_write_bypass();
      test_immediates();
      test_load_use();
      test_flush_priority();
      test_nop();
      test_back_to_back();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage directly downstream of the IF/ID register. It consumes IFID_Instr_out and IFID_pc_out.
- Contains the 32x32 integer register file (WB write port), the immediate generator, a minimal control decoder, load-use hazard detection and the ID/EX pipeline register.
- Drives pc_write and IFID_RegWrite back to the fetch stage. Accepts branch flush from EX.

Parameters:
- DATA_BITS, 32, datapath and instruction width
- ADDR_BITS, 32, PC width
- REG_ADDR_BITS, 5, register index width (32 registers)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- IFID_Instr_out  in  DATA_BITS  instruction from IF/ID
- IFID_pc_out  in  ADDR_BITS  PC of that instruction
- branch_flush  in  1  EX redirect taken (BranchCtrl != PC4); current ID instruction is wrong-path
- wb_RegWrite  in  1  WB write enable
- wb_rd  in  REG_ADDR_BITS  WB destination
- wb_data  in  DATA_BITS  WB write data
- pc_write  out  1  PC update enable to fetch (combinational)
- IFID_RegWrite  out  1  IF/ID load enable (combinational)
- IDEX_pc  out  ADDR_BITS  registered PC
- IDEX_rs1_data, IDEX_rs2_data  out  DATA_BITS  registered operands
- IDEX_imm  out  DATA_BITS  registered sign-extended immediate
- IDEX_rs1, IDEX_rs2, IDEX_rd  out  REG_ADDR_BITS  registered indices
- IDEX_opcode  out  7  registered opcode
- IDEX_funct3  out  3  registered funct3
- IDEX_funct7b5  out  1  registered instr[30]
- IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_Branch  out  1 each  registered controls

Behaviour:
- Reset (rst=0, async):
  - all 32 registers clear to 0
  - every IDEX_* output clears to 0 (bubble)
  - combinational outputs are don't-care during reset; they settle to 1 once rst=1 and no hazard is present
- Register file:
  - two async read ports indexed by instr[19:15] and instr[24:20]
  - one sync write port, active when wb_RegWrite=1 and wb_rd!=0
  - x0 always reads 0; writes to x0 are ignored
  - same-cycle bypass: if wb_RegWrite && wb_rd!=0 && wb_rd==rs, the read returns wb_data (write-before-read)
- Decode by opcode:
  - R 0110011; I-ALU 0010011; LOAD 0000011; STORE 0100011; BRANCH 1100011; JAL 1101111; JALR 1100111; LUI 0110111; AUIPC 0010111
  - RegWrite=1 for R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC
  - MemRead=1 for LOAD only; MemWrite=1 for STORE only; Branch=1 for BRANCH only
  - any other opcode, including 0x00000000 from an IF flush, decodes as NOP: all controls 0
- Immediate (sign bit is instr[31]):
  - I-type: instr[31:20] sign-extended
  - S-type: {instr[31:25],instr[11:7]}
  - B-type: {instr[31],instr[7],instr[30:25],instr[11:8],0}
  - U-type: {instr[31:12],12'b0}
  - J-type: {instr[31],instr[19:12],instr[20],instr[30:21],0}
  - all others: 0
- Source usage:
  - uses_rs1 for R, I-ALU, LOAD, STORE, BRANCH, JALR
  - uses_rs2 for R, STORE, BRANCH
- Load-use hazard: `hazard = IDEX_MemRead && IDEX_rd!=0 && ((uses_rs1 && IDEX_rd==rs1) || (uses_rs2 && IDEX_rd==rs2))`
- Stall (hazard && !branch_flush):
  - pc_write=0 and IFID_RegWrite=0
  - ID/EX loads a bubble (all IDEX_* = 0)
  - the instruction is held in IF/ID and re-decoded next cycle, so the stall lasts exactly 1 cycle
- Flush (branch_flush=1):
  - ID/EX loads a bubble
  - pc_write=1 and IFID_RegWrite=1 regardless of hazard (the wrong-path instruction must not stall fetch)
- Normal:
  - pc_write=1, IFID_RegWrite=1
  - ID/EX captures the decoded fields on the next rising edge; latency is 1 cycle
- Reset mid-operation: the pipeline register and register file clear immediately; no partial state survives.

Test Plan:
- Reset: drive rst=0 mid-stream -> all IDEX_* = 0 immediately; x1..x31 read 0 after rst=1.
- Write/bypass: wb_RegWrite=1, wb_rd=5, wb_data=0xDEADBEEF, same cycle ID holds add x6,x5,x0 -> next cycle IDEX_rs1_data=0xDEADBEEF; a write to x0 of 0x1234 -> x0 reads 0.
- Immediates:
  - addi x1,x0,-1 -> IDEX_imm=0xFFFFFFFF
  - beq with offset -4 -> IDEX_imm=0xFFFFFFFC
  - lui x2,0x12345 -> IDEX_imm=0x12345000
- Load-use: lw x3,0(x1) followed by add x4,x3,x2 -> one cycle with pc_write=0, IFID_RegWrite=0 and a bubble in ID/EX; the add issues the next cycle. lw x3 followed by lui x3 -> no stall.
- Flush priority: hazard present and branch_flush=1 in the same cycle -> pc_write=1, IFID_RegWrite=1, ID/EX bubble.
- NOP decode: IFID_Instr_out=0x00000000 -> IDEX_RegWrite/MemRead/MemWrite/Branch all 0 and IDEX_imm=0.
